// File: rtl/imp_period_meter_pkg.sv
// Shared timer definitions: counter width, default timeout and the meter FSM states.
// The impulse generator imports the same package so that period widths line up.
package imp_period_meter_pkg;

  localparam int CNT_W_DEFAULT   = $clog2(50_000_000);
  localparam int TIMEOUT_DEFAULT = 50_000_000;
  localparam int LOCK_DEFAULT    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/imp_period_meter_stats.sv
// Min/max tracker for measured periods, with a clear that can coincide with a new sample.
module imp_stats #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_stats,
  input  logic             meas,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max
);

  always_ff @(posedge clk) begin
    if (reset) begin
      period_min <= '1;
      period_max <= '0;
    end else if (clr_stats) begin
      // A sample arriving with the clear becomes the only sample in the new window.
      period_min <= meas ? value : '1;
      period_max <= meas ? value : '0;
    end else if (meas) begin
      if (value < period_min) period_min <= value;
      if (value > period_max) period_max <= value;
    end
  end

endmodule

// File: rtl/imp_period_meter.sv
// Measures clk-cycle distance between impulses; reports period, min/max, lock and timeout.
module imp_period_meter
  import imp_period_meter_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int LOCK_COUNT = LOCK_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imp,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_next;
  logic             first_meas;
  logic             meas;

  assign meas = (state == RUN) && imp;

  // The first measurement after IDLE has nothing valid to compare against.
  always_comb begin
    match_next = MW'(1);
    if (!first_meas && (cnt == period)) begin
      match_next = (match_cnt == LOCK_VAL) ? LOCK_VAL : match_cnt + MW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      match_cnt    <= '0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      first_meas   <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (imp) begin
            cnt        <= CNT_W'(1);
            state      <= RUN;
            timeout    <= 1'b0;
            first_meas <= 1'b1;
          end
        end
        RUN: begin
          if (imp) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= CNT_W'(1);
            match_cnt    <= match_next;
            locked       <= (match_next == LOCK_VAL);
            first_meas   <= 1'b0;
          end else if (cnt == TO_VAL) begin
            // Impulses stopped: keep the last period and stats, drop lock.
            state     <= IDLE;
            timeout   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  imp_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .reset     (reset),
    .clr_stats (clr_stats),
    .meas      (meas),
    .value     (cnt),
    .period_min(period_min),
    .period_max(period_max)
  );

endmodule

// File: tb/tb_imp_period_meter.sv
// Directed bench for imp_period_meter with TIMEOUT shortened to 100 cycles.
module tb_imp_period_meter;

  localparam int CNT_W = 26;
  localparam logic [31:0] ONES = 32'h03FF_FFFF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             imp = 1'b0;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [CNT_W-1:0] period_min;
  logic [CNT_W-1:0] period_max;
  logic             locked;
  logic             timeout;

  int n_vec = 0;
  int n_miss = 0;

  imp_period_meter #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (100),
    .LOCK_COUNT(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imp         (imp),
    .clr_stats   (clr_stats),
    .period      (period),
    .period_valid(period_valid),
    .period_min  (period_min),
    .period_max  (period_max),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick(input logic i);
    imp = i;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".period"}, 32'(period), 0);
    check({tag, ".valid"}, 32'(period_valid), 0);
    check({tag, ".min"}, 32'(period_min), ONES);
    check({tag, ".max"}, 32'(period_max), 0);
    check({tag, ".locked"}, 32'(locked), 0);
    check({tag, ".timeout"}, 32'(timeout), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    check_reset_state("rst");

    // Test 1: period 5, six measurements.
    tick(1'b1);
    check("t1.first_imp_valid", 32'(period_valid), 0);
    for (int m = 1; m <= 6; m++) begin
      gap(4);
      check($sformatf("t1.m%0d.pre_valid", m), 32'(period_valid), 0);
      tick(1'b1);
      check($sformatf("t1.m%0d.valid", m), 32'(period_valid), 1);
      check($sformatf("t1.m%0d.period", m), 32'(period), 5);
      check($sformatf("t1.m%0d.locked", m), 32'(locked), (m >= 4) ? 1 : 0);
    end
    check("t1.min", 32'(period_min), 5);
    check("t1.max", 32'(period_max), 5);

    // Test 3: switch to period 7; lock drops on first 7 and returns on the fourth.
    for (int m = 1; m <= 5; m++) begin
      gap(6);
      tick(1'b1);
      check($sformatf("t3.m%0d.period", m), 32'(period), 7);
      check($sformatf("t3.m%0d.locked", m), 32'(locked), (m >= 4) ? 1 : 0);
    end
    check("t3.min", 32'(period_min), 5);
    check("t3.max", 32'(period_max), 7);
    clr_stats = 1'b1;
    tick(1'b0);
    clr_stats = 1'b0;
    check("t3.clr.min", 32'(period_min), ONES);
    check("t3.clr.max", 32'(period_max), 0);
    gap(5);
    check("t3.clr_hold.max", 32'(period_max), 0);
    tick(1'b1);
    check("t3.after_clr.period", 32'(period), 7);
    check("t3.after_clr.min", 32'(period_min), 7);
    check("t3.after_clr.max", 32'(period_max), 7);
    check("t3.after_clr.locked", 32'(locked), 1);

    // Test 2: imp held high constantly.
    do_reset();
    tick(1'b1);
    check("t2.first_valid", 32'(period_valid), 0);
    for (int m = 1; m <= 5; m++) begin
      tick(1'b1);
      check($sformatf("t2.m%0d.valid", m), 32'(period_valid), 1);
      check($sformatf("t2.m%0d.period", m), 32'(period), 1);
      check($sformatf("t2.m%0d.locked", m), 32'(locked), (m >= 4) ? 1 : 0);
    end
    check("t2.min", 32'(period_min), 1);

    // Test 4: lock on period 10, then stop impulses until timeout.
    do_reset();
    tick(1'b1);
    for (int m = 1; m <= 4; m++) begin
      gap(9);
      tick(1'b1);
    end
    check("t4.locked_before", 32'(locked), 1);
    gap(99);
    check("t4.timeout_at_99", 32'(timeout), 0);
    check("t4.locked_at_99", 32'(locked), 1);
    tick(1'b0);
    check("t4.timeout_at_100", 32'(timeout), 1);
    check("t4.locked_dropped", 32'(locked), 0);
    check("t4.period_held", 32'(period), 10);
    gap(3);
    check("t4.timeout_sticky", 32'(timeout), 1);
    tick(1'b1);
    check("t4.restart.timeout", 32'(timeout), 0);
    check("t4.restart.valid", 32'(period_valid), 0);
    gap(2);
    tick(1'b1);
    check("t4.next.valid", 32'(period_valid), 1);
    check("t4.next.period", 32'(period), 3);
    check("t4.next.locked", 32'(locked), 0);

    // Test 5: impulse lands on cnt == TIMEOUT.
    gap(99);
    tick(1'b1);
    check("t5.period", 32'(period), 100);
    check("t5.valid", 32'(period_valid), 1);
    check("t5.timeout", 32'(timeout), 0);
    check("t5.max", 32'(period_max), 100);
    tick(1'b0);
    check("t5.timeout_after", 32'(timeout), 0);

    // Test 6: reset while locked mid-count, with imp asserted during reset.
    do_reset();
    tick(1'b1);
    for (int m = 1; m <= 4; m++) begin
      gap(8);
      tick(1'b1);
    end
    check("t6.locked_before", 32'(locked), 1);
    gap(3);
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    check_reset_state("t6.rst");
    tick(1'b1);
    check("t6.idle_valid", 32'(period_valid), 0);
    gap(4);
    tick(1'b1);
    check("t6.p5.min", 32'(period_min), 5);
    gap(8);
    clr_stats = 1'b1;
    tick(1'b1);
    clr_stats = 1'b0;
    check("t6.clr_meas.period", 32'(period), 9);
    check("t6.clr_meas.min", 32'(period_min), 9);
    check("t6.clr_meas.max", 32'(period_max), 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
